mul_pipe3_norm: RTL and testbench
=================================

# mul_pipe3_norm

Third stage of the pipelined floating-point multiplier. It consumes the raw product, pre-normalisation exponent, shift amounts and special-case flags from the partial-product stage. It normalises, rounds under the selected mode and packs the IEEE-754 result with exception flags. The stage is a two-register pipeline with a valid/ready handshake and a global stall, and it feeds the result writeback.

## Interface
- SIGN_W, 1: sign width
- EXPO_W, 8: exponent field width
- MANT_W, 23: fraction field width
- ZERO_D (localparam), $clog2(MANT_W+1): shift-count width base
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream operands valid
- in_ready  out  1  stage accepts this cycle
- sign_1  in  1  product sign
- expo_1  in  EXPO_W+2  signed two's-complement biased exponent, binary point of mant_1 after bit 2*MANT_W
- mant_1  in  2*MANT_W+2  raw significand product
- r_shift  in  ZERO_D+1  right shift for subnormal result (0 = none)
- l_shift  in  ZERO_D+1  left shift for subnormal operand (used only when r_shift==0)
- r_nan_in, inf_nan_in, r_0nan_in  in  1 each  result is NaN / infinity / zero
- rnd_in  in  2  00 RNE, 01 RTZ, 10 RDN, 11 RUP
- status_nv_in  in  1  invalid flag from classification
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- res_sign  out  1
- res_expo  out  EXPO_W
- res_mant  out  MANT_W
- flag_nv, flag_of, flag_uf, flag_nx  out  1 each

## Operation
- S1 (normalise):
  - If r_shift≠0, shift mant_1 right by r_shift. OR the shifted-out bits into sticky. Exponent becomes 0.
  - Otherwise shift mant_1 left by l_shift and subtract l_shift from expo_1.
  - Then, if bit 2*MANT_W+1 is set, shift right by 1 (shifted bit joins sticky) and add 1 to the exponent.
- S1 register contents: fraction = bits [2M-1:M], guard = bit M-1, sticky = OR of [M-2:0] plus the shifted-out bits, exponent (EXPO_W+2 signed), sign, rnd, special flags, nv.
- S2 (round): the increment is decided as follows.
  - RNE: guard & (sticky | lsb)
  - RTZ: 0
  - RDN: sign & (guard | sticky)
  - RUP: !sign & (guard | sticky)
- S2 carry: a carry out of the fraction adds 1 to the exponent. This covers subnormal 0→1 and normal overflow into the next binade.
- Overflow: when the final exponent ≥ 2^EXPO_W−1, set of=1 and nx=1.
  - Result is infinity for RNE, RUP with +, and RDN with −.
  - Otherwise result is max finite (expo 2^EXPO_W−2, mant all-ones).
- Inexact and underflow: nx = guard|sticky. uf = nx & (pre-round exponent ≤ 0, or a subnormal result).
- Specials override, in priority order r_nan > inf_nan > r_0nan:
  - r_nan: canonical qNaN (sign 0, expo all-ones, mant MSB only).
  - inf_nan: signed infinity.
  - r_0nan: signed zero.
  - For all specials, of/uf/nx are 0 and nv passes through.
- flag_nv is status_nv_in, delayed two stages.

## Timing
- Latency: 2 cycles from accepted input to out_valid.
- Enable: en = !out_valid || out_ready. in_ready = en. Both registers advance only when en=1. The valid bits shift in the same way (global stall, no bubble collapse).
- A transfer occurs on in_valid & in_ready, and on out_valid & out_ready.
- Output data is held stable while out_valid & !out_ready.
- Reset: both valid bits are 0, so out_valid=0 and in_ready=1 in the first cycle after reset. All data outputs and flags are 0. A reset mid-operation discards in-flight results with no output.
- Back-to-back throughput: 1 per cycle when out_ready is held 1.
- Simultaneous stall and new input: the input is not taken because in_ready=0. Upstream must hold its data.

## Structure
- Shared package mul_pkg holds:
  - the rounding-mode enum rnd_e (RNE, RTZ, RDN, RUP)
  - the stage-1 payload struct (sign, expo, frac, guard, sticky, rnd, specials, nv)
  - the QNAN_MANT constant
- One sub-module, mul_round: combinational rounding, overflow and special packing from the S1 payload. It is instantiated between the S1 and S2 registers.

## Test plan
- FP32 2.25:
  - Stimulus: mant_1=0x900000000000, expo_1=127, r_shift=l_shift=0, rnd=RNE.
  - Expect: result 0x40100000 two cycles later, all flags 0.
- Round-half-even tie:
  - Stimulus: fraction lsb=0, guard=1, sticky=0.
  - Expect: no increment under RNE, nx=1. Under RUP with a + sign, mant+1.
- Overflow:
  - Stimulus: expo_1=255 after normalisation, rnd=RTZ.
  - Expect: 0x7F7FFFFF with of=nx=1.
  - Same input with RNE: expect 0x7F800000.
- Subnormal:
  - Stimulus: r_shift=3, inexact bits.
  - Expect: res_expo=0, uf=nx=1.
  - Case where rounding carries to 0x00800000: expect expo=1.
- Specials: r_nan_in=1 with status_nv_in=1 → 0x7FC00000, flag_nv=1.
- Backpressure:
  - Stimulus: 4 back-to-back inputs, out_ready low for 3 cycles mid-stream.
  - Expect: in_ready drops the same cycle, no loss or duplication, results in order.
  - Assert rst mid-stream: out_valid=0 the next cycle.

Source files
------------

// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg
// Shared types and constants for the floating-point multiplier pipeline.
//   rnd_e         : rounding mode (RNE, RTZ, RDN, RUP)
//   s1_payload_t  : normalised operand captured in the first register of the
//                   normalise/round stage, consumed by mul_round
//   QNAN_MANT     : fraction field of the canonical quiet NaN
// ---------------------------------------------------------------------------
package mul_pkg;

  localparam int PKG_EXPO_W = 8;
  localparam int PKG_MANT_W = 23;

  typedef enum logic [1:0] {
    RNE = 2'b00,
    RTZ = 2'b01,
    RDN = 2'b10,
    RUP = 2'b11
  } rnd_e;

  // Exponent is kept two bits wider than the field and signed, so that
  // overflow (>= all-ones) and underflow (<= 0) remain visible before packing.
  typedef struct packed {
    logic                         sign;
    logic signed [PKG_EXPO_W+1:0] expo;
    logic [PKG_MANT_W-1:0]        frac;
    logic                         guard;
    logic                         sticky;
    rnd_e                         rnd;
    logic                         r_nan;
    logic                         inf_nan;
    logic                         r_0nan;
    logic                         nv;
  } s1_payload_t;

  localparam logic [PKG_MANT_W-1:0] QNAN_MANT = {1'b1, {(PKG_MANT_W-1){1'b0}}};

endpackage

// File: rtl/mul_round.sv
// ---------------------------------------------------------------------------
// mul_round
// Combinational rounding, overflow handling and special-value packing for
// the normalised payload held in the first pipeline register.
// Ports:
//   i_s1    in   normalised payload (sign, exponent, fraction, guard, sticky,
//                rounding mode, special-case flags, invalid flag)
//   o_sign  out  result sign
//   o_expo  out  result exponent field
//   o_mant  out  result fraction field
//   o_of    out  overflow flag
//   o_uf    out  underflow flag
//   o_nx    out  inexact flag
// ---------------------------------------------------------------------------
module mul_round
  import mul_pkg::*;
(
  input  s1_payload_t           i_s1,
  output logic                  o_sign,
  output logic [PKG_EXPO_W-1:0] o_expo,
  output logic [PKG_MANT_W-1:0] o_mant,
  output logic                  o_of,
  output logic                  o_uf,
  output logic                  o_nx
);

  localparam int EW = PKG_EXPO_W;
  localparam int MW = PKG_MANT_W;
  localparam logic signed [EW+1:0] EXPO_OVF = (EW+2)'((1 << EW) - 1);

  logic signed [EW+1:0] w_expo_pre;
  logic signed [EW+1:0] w_expo_fin;
  logic [MW:0]          w_sum;
  logic                 w_inc;
  logic                 w_carry;
  logic                 w_inexact;
  logic                 w_to_inf;

  always_comb begin
    w_expo_pre = i_s1.expo;

    case (i_s1.rnd)
      RNE:     w_inc = i_s1.guard & (i_s1.sticky | i_s1.frac[0]);
      RTZ:     w_inc = 1'b0;
      RDN:     w_inc = i_s1.sign & (i_s1.guard | i_s1.sticky);
      RUP:     w_inc = !i_s1.sign & (i_s1.guard | i_s1.sticky);
      default: w_inc = 1'b0;
    endcase

    // A carry out of the fraction either promotes a subnormal to the smallest
    // normal or moves a normal into the next binade; in both cases the
    // wrapped-to-zero fraction is already correct.
    w_sum      = {1'b0, i_s1.frac} + {{MW{1'b0}}, w_inc};
    w_carry    = w_sum[MW];
    w_expo_fin = w_expo_pre + $signed({{(EW+1){1'b0}}, w_carry});

    w_inexact  = i_s1.guard | i_s1.sticky;
    w_to_inf   = (i_s1.rnd == RNE) ||
                 ((i_s1.rnd == RUP) && !i_s1.sign) ||
                 ((i_s1.rnd == RDN) && i_s1.sign);

    o_sign = i_s1.sign;
    o_expo = w_expo_fin[EW-1:0];
    o_mant = w_sum[MW-1:0];
    o_of   = 1'b0;
    o_nx   = w_inexact;
    o_uf   = w_inexact & ((w_expo_pre <= 0) | (w_expo_fin == 0));

    if (w_expo_fin >= EXPO_OVF) begin
      o_of = 1'b1;
      o_nx = 1'b1;
      if (w_to_inf) begin
        o_expo = {EW{1'b1}};
        o_mant = '0;
      end else begin
        o_expo = {{(EW-1){1'b1}}, 1'b0};
        o_mant = {MW{1'b1}};
      end
    end

    // Special results override everything computed above.
    if (i_s1.r_nan) begin
      o_sign = 1'b0;
      o_expo = {EW{1'b1}};
      o_mant = QNAN_MANT;
      o_of   = 1'b0;
      o_uf   = 1'b0;
      o_nx   = 1'b0;
    end else if (i_s1.inf_nan) begin
      o_expo = {EW{1'b1}};
      o_mant = '0;
      o_of   = 1'b0;
      o_uf   = 1'b0;
      o_nx   = 1'b0;
    end else if (i_s1.r_0nan) begin
      o_expo = '0;
      o_mant = '0;
      o_of   = 1'b0;
      o_uf   = 1'b0;
      o_nx   = 1'b0;
    end
  end

endmodule

// File: rtl/mul_pipe3_norm.sv
// ---------------------------------------------------------------------------
// mul_pipe3_norm
// Final stage of the pipelined floating-point multiplier: normalises the raw
// significand product, rounds it under the requested mode and packs the
// IEEE-754 result with exception flags. Two registers deep, with a global
// stall: both registers advance only when the output is empty or taken.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      upstream handshake (in_ready = stage enable)
//   sign_1                   product sign
//   expo_1                   signed biased exponent (point after bit 2*MANT_W)
//   mant_1                   raw significand product
//   r_shift / l_shift        subnormal right shift / subnormal-operand left shift
//   r_nan_in, inf_nan_in,
//   r_0nan_in                special result select (NaN > Inf > zero)
//   rnd_in                   rounding mode (00 RNE, 01 RTZ, 10 RDN, 11 RUP)
//   status_nv_in             invalid flag, passed through
//   out_valid / out_ready    downstream handshake
//   res_sign/expo/mant       packed result
//   flag_nv/of/uf/nx         exception flags
// ---------------------------------------------------------------------------
module mul_pipe3_norm
  import mul_pkg::*;
#(
  parameter  int SIGN_W = 1,
  parameter  int EXPO_W = PKG_EXPO_W,
  parameter  int MANT_W = PKG_MANT_W,
  localparam int ZERO_D = $clog2(MANT_W + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SIGN_W-1:0]       sign_1,
  input  logic signed [EXPO_W+1:0] expo_1,
  input  logic [2*MANT_W+1:0]     mant_1,
  input  logic [ZERO_D:0]         r_shift,
  input  logic [ZERO_D:0]         l_shift,
  input  logic                    r_nan_in,
  input  logic                    inf_nan_in,
  input  logic                    r_0nan_in,
  input  logic [1:0]              rnd_in,
  input  logic                    status_nv_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SIGN_W-1:0]       res_sign,
  output logic [EXPO_W-1:0]       res_expo,
  output logic [MANT_W-1:0]       res_mant,
  output logic                    flag_nv,
  output logic                    flag_of,
  output logic                    flag_uf,
  output logic                    flag_nx
);

  localparam int PW = 2*MANT_W + 2;

  logic                    w_en;
  logic                    r_v1;
  logic                    r_v2;
  s1_payload_t             r_s1;
  s1_payload_t             w_s1;

  logic [PW-1:0]           w_shr;
  logic [PW-1:0]           w_shl;
  logic [PW-1:0]           w_pre;
  logic [PW-1:0]           w_norm;
  logic                    w_sticky_sh;
  logic                    w_sticky_n;
  logic signed [EXPO_W+1:0] w_expo_a;
  logic signed [EXPO_W+1:0] w_expo_n;
  logic                    w_unused_top;

  logic                    w_rs_sign;
  logic [EXPO_W-1:0]       w_rs_expo;
  logic [MANT_W-1:0]       w_rs_mant;
  logic                    w_rs_of;
  logic                    w_rs_uf;
  logic                    w_rs_nx;

  logic [SIGN_W-1:0]       r_res_sign;
  logic [EXPO_W-1:0]       r_res_expo;
  logic [MANT_W-1:0]       r_res_mant;
  logic                    r_flag_nv;
  logic                    r_flag_of;
  logic                    r_flag_uf;
  logic                    r_flag_nx;

  // ---------------------------------------------------------------- normalise
  always_comb begin
    w_shr = mant_1 >> r_shift;
    w_shl = mant_1 << l_shift;

    if (r_shift != '0) begin
      w_pre       = w_shr;
      // Bits lost by the right shift are exactly what fails to round-trip.
      w_sticky_sh = ((w_shr << r_shift) != mant_1);
      w_expo_a    = '0;
    end else begin
      w_pre       = w_shl;
      w_sticky_sh = 1'b0;
      w_expo_a    = expo_1 - (EXPO_W+2)'(l_shift);
    end

    // Product in [2,4): drop one more bit into sticky and bump the exponent.
    if (w_pre[PW-1]) begin
      w_norm     = w_pre >> 1;
      w_sticky_n = w_sticky_sh | w_pre[0];
      w_expo_n   = w_expo_a + (EXPO_W+2)'(1);
    end else begin
      w_norm     = w_pre;
      w_sticky_n = w_sticky_sh;
      w_expo_n   = w_expo_a;
    end

    w_s1.sign    = sign_1[0];
    w_s1.expo    = w_expo_n;
    w_s1.frac    = w_norm[2*MANT_W-1:MANT_W];
    w_s1.guard   = w_norm[MANT_W-1];
    w_s1.sticky  = w_sticky_n | (|w_norm[MANT_W-2:0]);
    w_s1.rnd     = rnd_e'(rnd_in);
    w_s1.r_nan   = r_nan_in;
    w_s1.inf_nan = inf_nan_in;
    w_s1.r_0nan  = r_0nan_in;
    w_s1.nv      = status_nv_in;
  end

  // Integer and hidden bits are implied by the exponent; not carried forward.
  assign w_unused_top = ^w_norm[PW-1:2*MANT_W];

  // ---------------------------------------------------------------- round
  mul_round u_round (
    .i_s1   (r_s1),
    .o_sign (w_rs_sign),
    .o_expo (w_rs_expo),
    .o_mant (w_rs_mant),
    .o_of   (w_rs_of),
    .o_uf   (w_rs_uf),
    .o_nx   (w_rs_nx)
  );

  // ---------------------------------------------------------------- pipeline
  assign w_en      = !r_v2 || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_v2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_s1       <= '0;
      r_res_sign <= '0;
      r_res_expo <= '0;
      r_res_mant <= '0;
      r_flag_nv  <= 1'b0;
      r_flag_of  <= 1'b0;
      r_flag_uf  <= 1'b0;
      r_flag_nx  <= 1'b0;
    end else if (w_en) begin
      r_v1 <= in_valid;
      r_v2 <= r_v1;
      // Data registers only load real transactions so bubbles leave the
      // previous (or reset) values in place.
      if (in_valid) begin
        r_s1 <= w_s1;
      end
      if (r_v1) begin
        r_res_sign <= SIGN_W'(w_rs_sign);
        r_res_expo <= w_rs_expo;
        r_res_mant <= w_rs_mant;
        r_flag_nv  <= r_s1.nv;
        r_flag_of  <= w_rs_of;
        r_flag_uf  <= w_rs_uf;
        r_flag_nx  <= w_rs_nx;
      end
    end
  end

  assign res_sign = r_res_sign;
  assign res_expo = r_res_expo;
  assign res_mant = r_res_mant;
  assign flag_nv  = r_flag_nv;
  assign flag_of  = r_flag_of;
  assign flag_uf  = r_flag_uf;
  assign flag_nx  = r_flag_nx;

endmodule

// File: tb/tb_mul_pipe3_norm.sv
// ---------------------------------------------------------------------------
// tb_mul_pipe3_norm
// Directed and randomized stimulus for mul_pipe3_norm, checked against an
// arithmetic reference model and a two-deep stall model of the handshake.
// ---------------------------------------------------------------------------
module tb_mul_pipe3_norm;

  typedef struct {
    logic       sign;
    logic [9:0] expo;
    logic [47:0] mant;
    logic [5:0] rs;
    logic [5:0] ls;
    logic [1:0] rnd;
    logic       nan;
    logic       inf;
    logic       zero;
    logic       nv;
  } stim_t;

  typedef struct {
    logic [31:0] word;
    logic        nv;
    logic        of;
    logic        uf;
    logic        nx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [0:0]  sign_1;
  logic [9:0]  expo_1;
  logic [47:0] mant_1;
  logic [5:0]  r_shift;
  logic [5:0]  l_shift;
  logic        r_nan_in;
  logic        inf_nan_in;
  logic        r_0nan_in;
  logic [1:0]  rnd_in;
  logic        status_nv_in;
  logic        out_valid;
  logic        out_ready;
  logic [0:0]  res_sign;
  logic [7:0]  res_expo;
  logic [22:0] res_mant;
  logic        flag_nv;
  logic        flag_of;
  logic        flag_uf;
  logic        flag_nx;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        exp_q[$];
  bit          m_v1, m_v2;
  bit          last_acc;
  logic [31:0] last_word;
  logic [3:0]  last_flags;
  stim_t       cur_stim;

  mul_pipe3_norm dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .sign_1       (sign_1),
    .expo_1       (expo_1),
    .mant_1       (mant_1),
    .r_shift      (r_shift),
    .l_shift      (l_shift),
    .r_nan_in     (r_nan_in),
    .inf_nan_in   (inf_nan_in),
    .r_0nan_in    (r_0nan_in),
    .rnd_in       (rnd_in),
    .status_nv_in (status_nv_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .res_sign     (res_sign),
    .res_expo     (res_expo),
    .res_mant     (res_mant),
    .flag_nv      (flag_nv),
    .flag_of      (flag_of),
    .flag_uf      (flag_uf),
    .flag_nx      (flag_nx)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model: value-level normalise / round / pack of one transaction.
  function automatic exp_t model(input stim_t s);
    exp_t        r;
    longint      e, ef;
    logic [63:0] m;
    logic [22:0] frac;
    bit          g, st, up, inf_sel;
    e  = longint'($signed(s.expo));
    st = 1'b0;
    if (s.rs != 0) begin
      m  = {16'd0, s.mant} >> s.rs;
      st = (({16'd0, s.mant} & ((64'd1 << s.rs) - 64'd1)) != 64'd0);
      e  = 0;
    end else begin
      m = {16'd0, s.mant} << s.ls;
      e = e - longint'(s.ls);
    end
    if (m >= (64'd1 << 47)) begin
      st = st | m[0];
      m  = m >> 1;
      e  = e + 1;
    end
    frac = m[45:23];
    g    = m[22];
    st   = st | (m[21:0] != 22'd0);
    case (s.rnd)
      2'd0:    up = g && (st || frac[0]);
      2'd1:    up = 1'b0;
      2'd2:    up = s.sign && (g || st);
      default: up = !s.sign && (g || st);
    endcase
    ef = e;
    if (up) begin
      if (frac == 23'h7FFFFF) begin
        frac = 23'd0;
        ef   = e + 1;
      end else begin
        frac = frac + 23'd1;
      end
    end
    r.nv = s.nv;
    r.of = 1'b0;
    r.nx = g | st;
    r.uf = r.nx && (e <= 0 || ef == 0);
    if (ef >= 255) begin
      r.of    = 1'b1;
      r.nx    = 1'b1;
      inf_sel = (s.rnd == 2'd0) || (s.rnd == 2'd3 && !s.sign) || (s.rnd == 2'd2 && s.sign);
      r.word  = inf_sel ? {s.sign, 8'hFF, 23'h0} : {s.sign, 8'hFE, 23'h7FFFFF};
    end else begin
      r.word = {s.sign, 8'(ef), frac};
    end
    if (s.nan || s.inf || s.zero) begin
      r.of = 1'b0;
      r.uf = 1'b0;
      r.nx = 1'b0;
      if (s.nan)      r.word = 32'h7FC00000;
      else if (s.inf) r.word = {s.sign, 8'hFF, 23'h0};
      else            r.word = {s.sign, 31'h0};
    end
    return r;
  endfunction

  function automatic stim_t mk(input logic sg, input int ex, input logic [47:0] mn,
                               input int rs, input int ls, input logic [1:0] rnd,
                               input logic nan, input logic nv);
    stim_t s;
    s.sign = sg;  s.expo = 10'(ex); s.mant = mn;
    s.rs = 6'(rs); s.ls = 6'(ls);   s.rnd = rnd;
    s.nan = nan;  s.inf = 1'b0;     s.zero = 1'b0; s.nv = nv;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t       s;
    int          k, mode;
    logic [47:0] base;
    s.sign = 1'($urandom);
    s.rnd  = 2'($urandom);
    s.nv   = 1'($urandom);
    k      = $urandom_range(0, 19);
    s.nan  = (k == 0) || (k == 3);
    s.inf  = (k == 1) || (k == 3);
    s.zero = (k == 2) || (k == 3);
    s.expo = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(250, 256))
                                         : 10'($urandom_range(20, 300));
    base   = {2'($urandom_range(1, 3)), 14'($urandom), $urandom};
    mode   = $urandom_range(0, 3);
    s.rs   = 6'd0;
    s.ls   = 6'd0;
    s.mant = base;
    if (mode == 0) begin
      s.rs = 6'($urandom_range(1, 30));
      s.ls = 6'($urandom_range(0, 10));
    end else if (mode == 1) begin
      s.ls   = 6'($urandom_range(1, 10));
      s.mant = {2'b01, base[45:0]} >> s.ls;
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input stim_t s);
    cur_stim     = s;
    sign_1       = s.sign;
    expo_1       = s.expo;
    mant_1       = s.mant;
    r_shift      = s.rs;
    l_shift      = s.ls;
    rnd_in       = s.rnd;
    r_nan_in     = s.nan;
    inf_nan_in   = s.inf;
    r_0nan_in    = s.zero;
    status_nv_in = s.nv;
  endtask

  // One clock: check handshake, score an output transfer, log an input
  // transfer, advance the stall model. Entered and left 1 time unit after
  // the rising edge.
  task automatic cycle();
    bit   en_m;
    exp_t e;
    #1;
    en_m = !m_v2 || out_ready;
    check("in_ready", {63'd0, in_ready}, {63'd0, en_m});
    check("out_valid", {63'd0, out_valid}, {63'd0, m_v2});
    last_acc = in_valid && en_m;
    if (m_v2 && out_ready) begin
      n_tests++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_output: observed %h expected none", {res_sign, res_expo, res_mant});
      end
      if (exp_q.size() > 0) begin
        e          = exp_q.pop_front();
        last_word  = {res_sign, res_expo, res_mant};
        last_flags = {flag_nv, flag_of, flag_uf, flag_nx};
        check("result", {32'd0, last_word}, {32'd0, e.word});
        check("flags", {60'd0, last_flags}, {60'd0, e.nv, e.of, e.uf, e.nx});
        $display("[TB] out %h flags nv%0b of%0b uf%0b nx%0b", last_word,
                 flag_nv, flag_of, flag_uf, flag_nx);
      end
    end
    if (last_acc) exp_q.push_back(model(cur_stim));
    @(posedge clk);
    if (en_m) begin
      m_v2 = m_v1;
      m_v1 = in_valid;
    end
    #1;
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) cycle();
  endtask

  task automatic send(input stim_t s);
    bit done;
    done = 1'b0;
    drive(s);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      cycle();
      done = last_acc;
    end
    n_tests++;
    assert (done) else begin
      n_fail++;
      $error("FAIL send_accept: observed no accept expected accept");
    end
    in_valid = 1'b0;
  endtask

  task automatic directed(input string tag, input stim_t s,
                          input logic [31:0] w, input logic [3:0] f);
    last_word  = 'x;
    last_flags = 'x;
    send(s);
    idle(3);
    check({tag, "_word"}, {32'd0, last_word}, {32'd0, w});
    check({tag, "_flags"}, {60'd0, last_flags}, {60'd0, f});
  endtask

  initial begin
    stim_t bp[4];
    stim_t cur;
    bit    have;
    int    idx;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive(mk(1'b0, 0, 48'd0, 0, 0, 2'd0, 1'b0, 1'b0));
    m_v1 = 1'b0;
    m_v2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_result", {32'd0, res_sign, res_expo, res_mant}, 64'd0);
    check("rst_flags", {60'd0, flag_nv, flag_of, flag_uf, flag_nx}, 64'd0);

    // Directed cases (flags ordered nv,of,uf,nx)
    directed("fp32_2p25", mk(1'b0, 127, 48'h900000000000, 0, 0, 2'd0, 1'b0, 1'b0),
             32'h40100000, 4'b0000);
    directed("tie_rne", mk(1'b0, 100, (48'd1 << 46) | (48'd1 << 22), 0, 0, 2'd0, 1'b0, 1'b0),
             32'h32000000, 4'b0001);
    directed("tie_rup", mk(1'b0, 100, (48'd1 << 46) | (48'd1 << 22), 0, 0, 2'd3, 1'b0, 1'b0),
             32'h32000001, 4'b0001);
    directed("tie_rne_odd", mk(1'b0, 100, (48'd1 << 46) | (48'd3 << 22), 0, 0, 2'd0, 1'b0, 1'b0),
             32'h32000002, 4'b0001);
    directed("ovf_rtz", mk(1'b0, 255, 48'd1 << 46, 0, 0, 2'd1, 1'b0, 1'b0),
             32'h7F7FFFFF, 4'b0101);
    directed("ovf_rne", mk(1'b0, 255, 48'd1 << 46, 0, 0, 2'd0, 1'b0, 1'b0),
             32'h7F800000, 4'b0101);
    directed("subnorm", mk(1'b0, 5, (48'd1 << 46) | 48'd5, 3, 0, 2'd0, 1'b0, 1'b0),
             32'h00100000, 4'b0011);
    directed("subnorm_carry", mk(1'b0, 5, 48'h7FFFFF800000, 1, 0, 2'd0, 1'b0, 1'b0),
             32'h00800000, 4'b0011);
    directed("qnan", mk(1'b1, 130, 48'h900000000000, 0, 0, 2'd0, 1'b1, 1'b1),
             32'h7FC00000, 4'b1000);

    // Backpressure: four back-to-back inputs, out_ready low for three cycles
    for (int i = 0; i < 4; i++) bp[i] = rand_stim();
    idx = 0;
    for (int c = 0; c < 14; c++) begin
      out_ready = !(c >= 2 && c <= 4);
      if (idx < 4) begin
        drive(bp[idx]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      cycle();
      if (last_acc) idx++;
    end
    check("bp_all_accepted", 64'(idx), 64'd4);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Randomized traffic with random stalls
    have = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!have && $urandom_range(0, 9) < 7) begin
        cur  = rand_stim();
        have = 1'b1;
      end
      if (have) begin
        drive(cur);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 9) < 7);
      cycle();
      if (last_acc) have = 1'b0;
    end
    idle(5);
    check("rand_drained", 64'(exp_q.size()), 64'd0);

    // Reset while two results are in flight: nothing may come out
    out_ready = 1'b1;
    drive(rand_stim());
    in_valid = 1'b1;
    cycle();
    drive(rand_stim());
    cycle();
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    rst = 1'b0;
    exp_q.delete();
    m_v1 = 1'b0;
    m_v2 = 1'b0;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
